// File: rtl/reaction_round_ctrl_pkg.sv
// Shared constants for the reaction game controller: state encodings,
// I/O widths, LFSR tap mask and the target one-hot decoder.
package reaction_round_ctrl_pkg;

  localparam int TIMER_W = 6;
  localparam int LED_W   = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_SHOW    = 3'd2;
  localparam logic [2:0] ST_HIT     = 3'd3;
  localparam logic [2:0] ST_MISS    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LED_W-1:0] target_onehot(input logic [3:0] idx);
    logic [LED_W-1:0] one;
    one = {{(LED_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every cycle out of reset so the
// target sequence depends on player timing.
module target_lfsr
  import reaction_round_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_2,
  input  logic        rst,
  output logic [15:0] value
);

  function automatic logic [15:0] galois_step(input logic [15:0] cur);
    logic [15:0] shifted;
    shifted = cur >> 1;
    return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) value <= SEED;
    else     value <= galois_step(value);
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reflex game sequencer: shows a random one-hot target, scores exact matches
// on the switches, and stops the round when the shared timer hits its end.
module reaction_round_ctrl
  import reaction_round_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_END   = 31,
  parameter int unsigned REACT_LIMIT = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk_2,
  input  logic               rst,
  input  logic               start,
  input  logic [LED_W-1:0]   sw,
  input  logic [TIMER_W-1:0] timer_in,
  output logic [LED_W-1:0]   led,
  output logic               score_inc,
  output logic               timer_en,
  output logic               timer_clr,
  output logic               game_over,
  output logic [2:0]         state_out
);

  localparam int CNT_W = (REACT_LIMIT > 1) ? $clog2(REACT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REACT_LIMIT - 1);

  logic [2:0]       state;
  logic [2:0]       next;
  logic [CNT_W-1:0] react_cnt;
  logic [15:0]      lfsr;
  logic             hit;
  logic             timer_end;
  logic             in_game;
  logic             unused_lfsr_bits;

  target_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_2 (clk_2),
    .rst   (rst),
    .value (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:4];

  assign hit       = (state == ST_SHOW) && (sw == led);
  assign timer_end = (timer_in == TIMER_W'(TIMER_END));
  assign in_game   = (state == ST_CLEAR) || (state == ST_SHOW) || (state == ST_HIT) ||
                     (state == ST_MISS)  || (state == ST_RELEASE);

  // Timer end overrides every in-game transition, including a same-cycle hit
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    if (start) next = ST_CLEAR;
      ST_CLEAR:   next = ST_SHOW;
      ST_SHOW: begin
        if (hit)                         next = ST_HIT;
        else if (react_cnt == CNT_LAST)  next = ST_MISS;
      end
      ST_HIT:     next = ST_RELEASE;
      ST_MISS:    next = ST_RELEASE;
      ST_RELEASE: if (sw == '0) next = ST_SHOW;
      ST_DONE:    if (start) next = ST_CLEAR;
      default:    next = ST_IDLE;
    endcase
    if (in_game && timer_end) next = ST_DONE;
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  // Counter restarts on every SHOW entry and holds at the last allowed cycle
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      react_cnt <= '0;
    end else if (state == ST_SHOW && next == ST_SHOW) begin
      if (react_cnt != CNT_LAST) react_cnt <= react_cnt + CNT_W'(1);
    end else begin
      react_cnt <= '0;
    end
  end

  // Target is latched from the LFSR only on the cycle SHOW is entered
  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else if (next == ST_SHOW) begin
      if (state != ST_SHOW) led <= target_onehot(lfsr[3:0]);
    end else begin
      led <= '0;
    end
  end

  assign score_inc = (state == ST_HIT);
  assign timer_clr = (state == ST_CLEAR);
  assign timer_en  = (state == ST_SHOW) || (state == ST_HIT) ||
                     (state == ST_MISS) || (state == ST_RELEASE);
  assign game_over = (state == ST_DONE);
  assign state_out = state;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed-vector bench for reaction_round_ctrl.
module tb_reaction_round_ctrl;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [5:0]  timer_in = 6'd0;
  logic [15:0] led;
  logic        score_inc, timer_en, timer_clr, game_over;
  logic [2:0]  state_out;

  int tests = 0;
  int fails = 0;

  reaction_round_ctrl #(.TIMER_END(31), .REACT_LIMIT(12), .LFSR_SEED(16'hACE1)) dut (
    .clk_2     (clk_2),
    .rst       (rst),
    .start     (start),
    .sw        (sw),
    .timer_in  (timer_in),
    .led       (led),
    .score_inc (score_inc),
    .timer_en  (timer_en),
    .timer_clr (timer_clr),
    .game_over (game_over),
    .state_out (state_out)
  );

  always #5 clk_2 = ~clk_2;

  // Reference LFSR: Galois, taps 16,14,13,11; m_prev is the value that was
  // live during the previous cycle, i.e. the one a SHOW entry captures.
  logic [15:0] m, m_prev;
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction
  always @(posedge clk_2 or posedge rst) begin
    if (rst) begin m <= 16'hACE1; m_prev <= 16'hACE1; end
    else begin m_prev <= m; m <= ref_step(m); end
  end

  function automatic logic [15:0] exp_led();
    logic [15:0] one;
    one = 16'h0001;
    return one << m_prev[3:0];
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (state_out !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state_out); end
    tests++; if (led !== 16'h0000) begin fails++; $display("FAIL reset_led got %h want 0000", led); end
    tests++; if ({score_inc, timer_en, timer_clr, game_over} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs got %b want 0000", {score_inc, timer_en, timer_clr, game_over}); end
    do_reset();
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    tests++; if (state_out !== 3'd1 || timer_clr !== 1'b1 || timer_en !== 1'b0) begin
      fails++; $display("FAIL start_clear got st=%0d clr=%b en=%b want st=1 clr=1 en=0", state_out, timer_clr, timer_en); end
    start = 1'b0;
    tick();
    tests++; if (state_out !== 3'd2 || timer_clr !== 1'b0 || timer_en !== 1'b1) begin
      fails++; $display("FAIL start_show got st=%0d clr=%b en=%b want st=2 clr=0 en=1", state_out, timer_clr, timer_en); end
    // Seed ACE1 steps once to E270, so the first target is bit 0
    tests++; if (led !== 16'h0001) begin fails++; $display("FAIL start_first_led got %h want 0001", led); end
  endtask

  task automatic test_hit();
    int pulses;
    repeat (3) tick();
    sw = led;
    tick();
    tests++; if (state_out !== 3'd3 || score_inc !== 1'b1 || led !== 16'h0000) begin
      fails++; $display("FAIL hit_pulse got st=%0d inc=%b led=%h want st=3 inc=1 led=0000", state_out, score_inc, led); end
    pulses = 0;
    repeat (4) begin tick(); if (score_inc) pulses++; end
    tests++; if (pulses !== 0 || state_out !== 3'd5) begin
      fails++; $display("FAIL hit_hold got pulses=%0d st=%0d want pulses=0 st=5", pulses, state_out); end
    sw = 16'h0000;
    tick();
    tests++; if (state_out !== 3'd2 || led !== exp_led()) begin
      fails++; $display("FAIL hit_new_target got st=%0d led=%h want st=2 led=%h", state_out, led, exp_led()); end
  endtask

  task automatic test_wrong_extra();
    int pulses;
    int shows;
    sw = led | ((led == 16'h0001) ? 16'h0002 : 16'h0001);
    start = 1'b1;
    pulses = 0; shows = 0;
    repeat (11) begin tick(); if (score_inc) pulses++; if (state_out == 3'd2) shows++; end
    start = 1'b0;
    tests++; if (shows !== 11 || pulses !== 0) begin
      fails++; $display("FAIL extra_show got shows=%0d pulses=%0d want shows=11 pulses=0", shows, pulses); end
    tick();
    tests++; if (state_out !== 3'd4 || score_inc !== 1'b0 || led !== 16'h0000) begin
      fails++; $display("FAIL extra_miss got st=%0d inc=%b led=%h want st=4 inc=0 led=0000", state_out, score_inc, led); end
    repeat (2) tick();
    tests++; if (state_out !== 3'd5 || timer_en !== 1'b1) begin
      fails++; $display("FAIL extra_release_wait got st=%0d en=%b want st=5 en=1", state_out, timer_en); end
    sw = 16'h0000;
    tick();
    tests++; if (state_out !== 3'd2 || led !== exp_led()) begin
      fails++; $display("FAIL extra_new_target got st=%0d led=%h want st=2 led=%h", state_out, led, exp_led()); end
  endtask

  task automatic test_final_cycle();
    repeat (11) tick();
    tests++; if (state_out !== 3'd2) begin fails++; $display("FAIL last_still_show got st=%0d want 2", state_out); end
    sw = led;
    tick();
    tests++; if (state_out !== 3'd3 || score_inc !== 1'b1) begin
      fails++; $display("FAIL last_hit got st=%0d inc=%b want st=3 inc=1", state_out, score_inc); end
    sw = 16'h0000;
    repeat (2) tick();
    tests++; if (state_out !== 3'd2 || led !== exp_led()) begin
      fails++; $display("FAIL last_new_target got st=%0d led=%h want st=2 led=%h", state_out, led, exp_led()); end
  endtask

  task automatic test_late_hit();
    logic [15:0] target;
    int pulses;
    target = led;
    repeat (12) tick();
    tests++; if (state_out !== 3'd4 || score_inc !== 1'b0) begin
      fails++; $display("FAIL late_miss got st=%0d inc=%b want st=4 inc=0", state_out, score_inc); end
    sw = target;
    pulses = 0;
    repeat (2) begin tick(); if (score_inc) pulses++; end
    tests++; if (pulses !== 0 || state_out !== 3'd5) begin
      fails++; $display("FAIL late_no_pulse got pulses=%0d st=%0d want pulses=0 st=5", pulses, state_out); end
    sw = 16'h0000;
    tick();
    tests++; if (state_out !== 3'd2 || led !== exp_led()) begin
      fails++; $display("FAIL late_new_target got st=%0d led=%h want st=2 led=%h", state_out, led, exp_led()); end
  endtask

  task automatic test_hit_then_timer();
    sw = led;
    tick();
    tests++; if (score_inc !== 1'b1) begin fails++; $display("FAIL hit_timer_pulse got %b want 1", score_inc); end
    timer_in = 6'd31;
    tick();
    tests++; if (state_out !== 3'd6 || score_inc !== 1'b0 || game_over !== 1'b1) begin
      fails++; $display("FAIL hit_timer_done got st=%0d inc=%b over=%b want st=6 inc=0 over=1", state_out, score_inc, game_over); end
    timer_in = 6'd0; sw = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if (state_out !== 3'd2 || led !== exp_led()) begin
      fails++; $display("FAIL hit_timer_restart got st=%0d led=%h want st=2 led=%h", state_out, led, exp_led()); end
  endtask

  task automatic test_timer_end();
    sw = led;
    timer_in = 6'd31;
    tick();
    tests++; if (state_out !== 3'd6 || game_over !== 1'b1 || timer_en !== 1'b0) begin
      fails++; $display("FAIL tend_done got st=%0d over=%b en=%b want st=6 over=1 en=0", state_out, game_over, timer_en); end
    tests++; if (score_inc !== 1'b0 || led !== 16'h0000) begin
      fails++; $display("FAIL tend_no_score got inc=%b led=%h want inc=0 led=0000", score_inc, led); end
    timer_in = 6'd0; sw = 16'h0000;
    tick();
    tests++; if (state_out !== 3'd6) begin fails++; $display("FAIL tend_hold got st=%0d want 6", state_out); end
    start = 1'b1;
    tick();
    tests++; if (state_out !== 3'd1 || timer_clr !== 1'b1 || game_over !== 1'b0) begin
      fails++; $display("FAIL tend_restart got st=%0d clr=%b over=%b want st=1 clr=1 over=0", state_out, timer_clr, game_over); end
    start = 1'b0;
    tick();
    tests++; if (timer_clr !== 1'b0 || timer_en !== 1'b1 || led !== exp_led()) begin
      fails++; $display("FAIL tend_show got clr=%b en=%b led=%h want clr=0 en=1 led=%h", timer_clr, timer_en, led, exp_led()); end
  endtask

  task automatic test_async_reset();
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    tests++; if (led !== 16'h0000 || state_out !== 3'd0) begin
      fails++; $display("FAIL arst_led_state got led=%h st=%0d want led=0000 st=0", led, state_out); end
    tests++; if ({score_inc, timer_en, timer_clr, game_over} !== 4'b0000) begin
      fails++; $display("FAIL arst_outs got %b want 0000", {score_inc, timer_en, timer_clr, game_over}); end
    repeat (2) @(negedge clk_2);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if (state_out !== 3'd2 || led !== 16'h0001) begin
      fails++; $display("FAIL arst_reseed got st=%0d led=%h want st=2 led=0001", state_out, led); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_wrong_extra();
    test_final_cycle();
    test_late_hit();
    test_hit_then_timer();
    test_timer_end();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
